i2s_rx_deserializer: RTL and testbench
======================================

Name: i2s_rx_deserializer

Overview:
- RTL I2S receiver (Philips format). Oversamples the external SCLK/WS/SD lines on the system clock and deserializes MSB-first left/right words.
- Presents each completed stereo pair on a valid/ready output.
- The I2S transmitter agent BFM drives it in the AVIP top level; the receiver agent BFM monitors the same serial lines.

Parameters:
- DATA_WIDTH, 16: output word width per channel (8..32).
- SYNC_STAGES, 2: synchronizer flops on sclk/ws/sd inputs (≥2).

Ports:
- clk  input  1  system clock; must be ≥4× SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- i2s_sclk  input  1  serial bit clock, asynchronous to clk.
- i2s_ws  input  1  word select; 0 = left, 1 = right.
- i2s_sd  input  1  serial data.
- out_valid  output  1  stereo pair available.
- out_ready  input  1  consumer accepts the pair.
- out_left  output  DATA_WIDTH  left sample.
- out_right  output  DATA_WIDTH  right sample.
- overrun  output  1  one-cycle pulse: a completed pair was dropped.

Behaviour:
- Sync: i2s_sclk, i2s_ws and i2s_sd each pass through SYNC_STAGES flops. sclk_rise = synced sclk high while its previous-cycle copy is low.
- All serial sampling happens only in cycles where sclk_rise=1. On such a cycle, ws_s and sd_s are sampled and ws_s is compared with ws_last, the WS value from the previous sclk_rise.
- Word boundary: a sclk_rise where ws_s≠ws_last.
  - The sd bit sampled on that edge is the LSB/final bit of the word for channel ws_last (one-bit WS lead).
  - The word completes on that edge.
  - bit_cnt resets to 0 for the new word.
- Bit placement: bit number k of a word (k = 0 for MSB) goes to position DATA_WIDTH-1-k while k < DATA_WIDTH.
  - Bits with k ≥ DATA_WIDTH are discarded (truncation).
  - Short words are zero-padded in the LSBs (left-justified).
  - bit_cnt saturates at 63.
- FSM states:
  - SYNC_WAIT (reset state): nothing is stored. On the first boundary, go to CAP_L if the new ws is 0, else CAP_R. The word ending at this boundary is discarded.
  - CAP_L: assembling left word. On boundary, latch left_hold and set left_ok, then go to CAP_R.
  - CAP_R: assembling right word. On boundary, go to CAP_L; if left_ok, the pair {left_hold, right word} completes this cycle; clear left_ok.
- A right word without a preceding captured left word is discarded; no pair is formed.
- Output register (single entry):
  - Pair completes and (!out_valid or out_ready): load out_left/out_right and set out_valid on the next clk edge.
  - Pair completes while out_valid and !out_ready: keep the held pair, drop the new one, pulse overrun for one cycle.
  - out_valid and out_ready with no completing pair: clear out_valid.
  - Simultaneous accept and completion: new pair loaded, out_valid stays 1, no overrun.
- out_left/out_right remain stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises SYNC_STAGES+1 clk cycles after the first clk edge that samples raw i2s_sclk high on the boundary edge.
- Reset (any time, including mid-word):
  - out_valid=0, out_left=0, out_right=0, overrun=0.
  - Shift register, bit_cnt, left_ok and synchronizers cleared; ws_last=0; state=SYNC_WAIT.
  - The partial word in progress is lost.

Optional Feature:
- Macro: I2S_RX_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit, reset 0). It pulses for one clk on any boundary in CAP_L/CAP_R where the completed word's bit count ≠ DATA_WIDTH. Capture and truncation/padding are unchanged.
- Undefined: port and check absent; length mismatches are handled silently by truncation/padding.

Decomposition:
- Package i2s_rx_pkg:
  - state enum {SYNC_WAIT, CAP_L, CAP_R};
  - channel constants LEFT_CH=1'b0, RIGHT_CH=1'b1;
  - BIT_CNT_W=6.
- Sub-module i2s_rx_sync:
  - parameterized SYNC_STAGES synchronizer for the three inputs;
  - sclk rising-edge detector;
  - outputs sclk_rise, ws_s, sd_s.

Test Plan (DATA_WIDTH=16, SCLK=clk/8):
1. Reset, one dummy frame, then left=16'hA5C3 / right=16'h3C5A with out_ready=1 → out_valid one cycle with those values; the dummy frame produces no output.
2. out_ready=0 for three frames (0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666) → 0x1111/0x2222 held stable; overrun pulses exactly twice; releasing ready yields 0x1111/0x2222 only.
3. 18-bit words 18'h3FFFE / 18'h2AAAA → out 16'hFFFF / 16'hAAAA; 12-bit words 12'hABC / 12'h123 → 16'hABC0 / 16'h1230.
4. Assert rst for one cycle mid-left-word → all outputs 0; the next partial word is discarded; the first full frame afterward is output correctly.
5. out_ready asserted in exactly the cycle a second pair completes while the first is valid → first accepted, second loaded next cycle, overrun stays 0.
6. With I2S_RX_FRAME_ERR_EN: 18-bit words → frame_err pulses at every boundary; 16-bit words → frame_err never asserts.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receive deserializer.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    CAP_L,
    CAP_R
  } state_t;

  localparam logic LEFT_CH  = 1'b0;
  localparam logic RIGHT_CH = 1'b1;

  localparam int BIT_CNT_W = 6;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings SCLK/WS/SD into the clk domain and flags rising edges of SCLK.
// The edge flag and the sampled WS/SD are registered together so they stay aligned.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ws,
  input  logic sd,
  output logic sclk_rise,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_prev;

  // Synchronizer chains plus a one-cycle-delayed copy of SCLK for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      ws_s      <= 1'b0;
      sd_s      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], ws};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      ws_s      <= ws_sync[SYNC_STAGES-1];
      sd_s      <= sd_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Philips-format I2S receiver: deserializes MSB-first left/right words and
// presents each stereo pair on a single-entry valid/ready output register.
// Optional feature macro: I2S_RX_FRAME_ERR_EN adds a frame_err pulse output
// for words whose length differs from DATA_WIDTH.
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2s_sclk,
  input  logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  overrun
`ifdef I2S_RX_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  logic                  sclk_rise;
  logic                  ws_s;
  logic                  sd_s;
  state_t                state;
  state_t                state_next;
  logic                  ws_last;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  left_ok;
  logic                  boundary;
  logic                  pair_done;
  logic                  left_latch;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (i2s_sclk),
    .ws       (i2s_ws),
    .sd       (i2s_sd),
    .sclk_rise(sclk_rise),
    .ws_s     (ws_s),
    .sd_s     (sd_s)
  );

  assign boundary = sclk_rise && (ws_s != ws_last);

  // Word including the bit sampled now; bits past DATA_WIDTH find no slot and are dropped.
  always_comb begin
    cur_word = shift_reg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1 - i)) begin
        cur_word[i] = sd_s;
      end
    end
  end

  // Channel FSM: decides what happens to the word that ends at a WS change.
  always_comb begin
    state_next = state;
    pair_done  = 1'b0;
    left_latch = 1'b0;
    if (boundary) begin
      case (state)
        SYNC_WAIT: state_next = (ws_s == LEFT_CH) ? CAP_L : CAP_R;
        CAP_L: begin
          left_latch = 1'b1;
          state_next = CAP_R;
        end
        CAP_R: begin
          pair_done  = left_ok;
          state_next = CAP_L;
        end
        default: state_next = SYNC_WAIT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC_WAIT;
    else     state <= state_next;
  end

  // Serial assembly: shift in on each SCLK rise, restart on a word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_last   <= LEFT_CH;
      bit_cnt   <= '0;
      shift_reg <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
    end else if (sclk_rise) begin
      ws_last <= ws_s;
      if (boundary) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else begin
        shift_reg <= cur_word;
        if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
      if (left_latch) begin
        left_hold <= cur_word;
        left_ok   <= 1'b1;
      end else if (boundary && state == CAP_R) begin
        left_ok <= 1'b0;
      end
    end
  end

  // Single-entry output register: a pair arriving while the slot is blocked is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pair_done) begin
        if (!out_valid || out_ready) begin
          out_left  <= left_hold;
          out_right <= cur_word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  // Flag captured words whose received length is not exactly DATA_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= boundary && (state == CAP_L || state == CAP_R) &&
                   (bit_cnt != BIT_CNT_W'(DATA_WIDTH - 1));
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Self-checking bench for i2s_rx_deserializer (DATA_WIDTH=16, SCLK=clk/8).
// Build with I2S_RX_FRAME_ERR_EN defined to also exercise frame_err.
module tb_i2s_rx_deserializer;

  localparam int DW = 16;
  localparam int SYNC_STAGES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i2s_sclk;
  logic          i2s_ws;
  logic          i2s_sd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_right;
  logic          overrun;
`ifdef I2S_RX_FRAME_ERR_EN
  logic          frame_err;
`endif

  i2s_rx_deserializer #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i2s_sclk (i2s_sclk),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_left (out_left),
    .out_right(out_right),
    .overrun  (overrun)
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] left_word;
    logic [31:0] right_word;
    int          len;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          overrun_cnt = 0;
  int          frame_err_cnt = 0;
  bit          unstable = 1'b0;
  bit          hold_prev_valid = 1'b0;
  logic [31:0] hold_prev = '0;

  // Observer: records accepted pairs, counts pulses, watches held-data stability.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) got_q.push_back({out_left, out_right});
    if (overrun) overrun_cnt++;
`ifdef I2S_RX_FRAME_ERR_EN
    if (frame_err) frame_err_cnt++;
`endif
    if (hold_prev_valid && out_valid && ({out_left, out_right} != hold_prev)) unstable = 1'b1;
    hold_prev_valid = out_valid && !out_ready && !rst;
    hold_prev = {out_left, out_right};
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  // Left-justified DATA_WIDTH view of an n-bit MSB-first word.
  function automatic logic [15:0] justify(input logic [31:0] w, input int n);
    logic [31:0] t;
    t = w & ((32'd1 << n) - 32'd1);
    if (n >= DW) t = t >> (n - DW);
    else         t = t << (DW - n);
    return t[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One serial bit: WS/SD change with SCLK falling, receiver samples on the rise.
  task automatic sendBit(input logic ws, input logic sd, input bit pulse_ready);
    i2s_sclk = 1'b0;
    i2s_ws   = ws;
    i2s_sd   = sd;
    repeat (4) @(negedge clk);
    i2s_sclk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pulse_ready && i == 2) out_ready = 1'b1;
      if (pulse_ready && i == 3) out_ready = 1'b0;
    end
    i2s_sclk = 1'b0;
  endtask

  // Bits first..stop-1 of an len-bit word; WS flips one bit early (on the LSB).
  task automatic sendWord(input logic [31:0] w, input int len, input int first, input int stop,
                          input logic ch, input bit pulse_last);
    for (int k = first; k < stop; k++) begin
      sendBit((k == len - 1) ? ~ch : ch, w[len-1-k], pulse_last && (k == len - 1));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r,
                               input int llen, input int rlen, input bit pulse);
    sendWord(l, llen, 0, llen, 1'b0, 1'b0);
    sendWord(r, rlen, 0, rlen, 1'b1, pulse);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int          ov0;
    int          fe0;
    logic [31:0] l;
    logic [31:0] r;
    int          llen;
    int          rlen;

    vecs[0] = '{32'hA5C3,  32'h3C5A,  16, 16'hA5C3, 16'h3C5A};
    vecs[1] = '{32'h3FFFE, 32'h2AAAA, 18, 16'hFFFF, 16'hAAAA};
    vecs[2] = '{32'hABC,   32'h123,   12, 16'hABC0, 16'h1230};
    vecs[3] = '{32'hFFFF,  32'h0001,  16, 16'hFFFF, 16'h0001};
    vecs[4] = '{32'h8000,  32'h7FFF,  16, 16'h8000, 16'h7FFF};

    rst = 1'b1; i2s_sclk = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_left", 32'(out_left), 32'd0);
    checkOutput("reset_right", 32'(out_right), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);

    $display("[TB] dummy frame and vector table");
    applyStimulus(32'hFFFF, 32'hFFFF, 16, 16, 1'b0);
    settle();
    checkOutput("dummy_no_output", 32'(got_q.size()), 32'd0);
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      applyStimulus(vecs[v].left_word, vecs[v].right_word, vecs[v].len, vecs[v].len, 1'b0);
      settle();
      checkOutput($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0)
        checkOutput($sformatf("vec%0d_pair", v), got_q[0], {vecs[v].exp_left, vecs[v].exp_right});
    end

    $display("[TB] backpressure and overrun");
    got_q.delete();
    out_ready = 1'b0;
    ov0 = overrun_cnt;
    unstable = 1'b0;
    applyStimulus(32'h1111, 32'h2222, 16, 16, 1'b0);
    applyStimulus(32'h3333, 32'h4444, 16, 16, 1'b0);
    applyStimulus(32'h5555, 32'h6666, 16, 16, 1'b0);
    settle();
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_held_pair", {out_left, out_right}, {16'h1111, 16'h2222});
    checkOutput("bp_overrun_count", 32'(overrun_cnt - ov0), 32'd2);
    checkOutput("bp_stable", 32'(unstable), 32'd0);
    checkOutput("bp_none_accepted", 32'(got_q.size()), 32'd0);
    out_ready = 1'b1;
    settle();
    checkOutput("bp_release_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("bp_release_pair", got_q[0], {16'h1111, 16'h2222});
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);

    $display("[TB] accept in the completion cycle");
    got_q.delete();
    out_ready = 1'b0;
    applyStimulus(32'hAAAA, 32'h5555, 16, 16, 1'b0);
    settle();
    ov0 = overrun_cnt;
    applyStimulus(32'h1234, 32'h5678, 16, 16, 1'b1);
    checkOutput("sim_valid", 32'(out_valid), 32'd1);
    checkOutput("sim_loaded_pair", {out_left, out_right}, {16'h1234, 16'h5678});
    checkOutput("sim_first_accepted", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("sim_first_pair", got_q[0], {16'hAAAA, 16'h5555});
    checkOutput("sim_no_overrun", 32'(overrun_cnt - ov0), 32'd0);
    out_ready = 1'b1;
    settle();
    checkOutput("sim_drain_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() > 1) checkOutput("sim_second_pair", got_q[1], {16'h1234, 16'h5678});

    $display("[TB] reset mid-word");
    got_q.delete();
    out_ready = 1'b0;
    applyStimulus(32'hCAFE, 32'hBEEF, 16, 16, 1'b0);
    settle();
    sendWord(32'h1357, 16, 0, 8, 1'b0, 1'b0);
    doReset();
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_left", 32'(out_left), 32'd0);
    checkOutput("rst_mid_right", 32'(out_right), 32'd0);
    checkOutput("rst_mid_overrun", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    sendWord(32'h1357, 16, 8, 16, 1'b0, 1'b0);
    sendWord(32'h2468, 16, 0, 16, 1'b1, 1'b0);
    settle();
    checkOutput("rst_partial_dropped", 32'(got_q.size()), 32'd0);
    applyStimulus(32'h0F0F, 32'hF0F0, 16, 16, 1'b0);
    settle();
    checkOutput("rst_after_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) checkOutput("rst_after_pair", got_q[0], {16'h0F0F, 16'hF0F0});

    $display("[TB] randomized frames against reference model");
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 20; f++) begin
      llen = int'($urandom_range(12, 20));
      rlen = int'($urandom_range(12, 20));
      l = $urandom;
      r = $urandom;
      exp_q.push_back({justify(l, llen), justify(r, rlen)});
      applyStimulus(l, r, llen, rlen, 1'b0);
    end
    settle();
    checkOutput("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checkOutput($sformatf("rand_pair%0d", i), got_q[i], exp_q[i]);
    end

`ifdef I2S_RX_FRAME_ERR_EN
    $display("[TB] frame length error flag");
    settle();
    fe0 = frame_err_cnt;
    applyStimulus(32'h3FFFE, 32'h2AAAA, 18, 18, 1'b0);
    applyStimulus(32'h12345, 32'h0ABCD, 18, 18, 1'b0);
    settle();
    checkOutput("ferr_18bit_pulses", 32'(frame_err_cnt - fe0), 32'd4);
    fe0 = frame_err_cnt;
    applyStimulus(32'hA5C3, 32'h3C5A, 16, 16, 1'b0);
    applyStimulus(32'h1234, 32'h5678, 16, 16, 1'b0);
    settle();
    checkOutput("ferr_16bit_pulses", 32'(frame_err_cnt - fe0), 32'd0);
`else
    fe0 = frame_err_cnt;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
